// File: rtl/vg_pkg.sv
// Shared opcode/state types and address widths for the vector-generator fetch unit.
package vg_pkg;
    localparam int WADDR_W = 12;
    localparam int BADDR_W = WADDR_W + 1;

    typedef enum logic [2:0] {
        OP_VCTR = 3'd0,
        OP_HALT = 3'd1,
        OP_SVEC = 3'd2,
        OP_STAT = 3'd3,
        OP_CNTR = 3'd4,
        OP_JSR  = 3'd5,
        OP_RTS  = 3'd6,
        OP_JMP  = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FETCH_EXT,
        ST_EXEC,
        ST_ISSUE
    } state_t;

    // Opcodes that are handed to the beam engine rather than executed locally.
    function automatic logic is_issued(opcode_t op);
        return (op == OP_VCTR) || (op == OP_SVEC) || (op == OP_STAT) || (op == OP_CNTR);
    endfunction
endpackage

// File: rtl/vg_fetch_if.sv
// Vector-RAM read port plus the instruction handshake towards the beam engine.
interface vg_fetch_if;
    import vg_pkg::*;

    logic [BADDR_W-1:0] mem_addr;
    logic [7:0]         mem_data;
    logic               instr_valid;
    logic               instr_ready;
    logic [2:0]         instr_op;
    logic [31:0]        instr_data;

    modport master (
        output mem_addr,
        input  mem_data,
        output instr_valid,
        input  instr_ready,
        output instr_op,
        output instr_data
    );

    modport slave (
        input  mem_addr,
        output mem_data,
        input  instr_valid,
        output instr_ready,
        input  instr_op,
        input  instr_data
    );
endinterface

// File: rtl/vg_return_stack.sv
// Subroutine return-address LIFO; the top entry is visible without a read cycle.
module vg_return_stack
    import vg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               push,
    input  logic               pop,
    input  logic [WADDR_W-1:0] push_data,
    output logic [WADDR_W-1:0] top,
    output logic               full,
    output logic               empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W:0]       count_reg;
    logic [WADDR_W-1:0]   entry_reg [DEPTH];
    logic [PTR_W-1:0]     wr_idx;
    logic [PTR_W-1:0]     rd_idx;

    assign wr_idx = count_reg[PTR_W-1:0];
    assign rd_idx = PTR_W'(count_reg - (PTR_W+1)'(1));
    assign full   = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty  = (count_reg == '0);
    assign top    = entry_reg[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (push && !full) begin
            count_reg <= count_reg + (PTR_W+1)'(1);
        end else if (pop && !empty) begin
            count_reg <= count_reg - (PTR_W+1)'(1);
        end
    end

    // Entry storage needs no reset: the count alone defines what is valid.
    always_ff @(posedge clk) begin
        if (!clear && push && !full) begin
            entry_reg[wr_idx] <= push_data;
        end
    end
endmodule

// File: rtl/vg_fetch.sv
// Vector-generator instruction fetch/sequencer: reads 16-bit words from vector RAM,
// executes control flow locally and hands draw instructions to the beam engine.
module vg_fetch
    import vg_pkg::*;
#(
    parameter int                 STACK_DEPTH = 4,
    parameter logic [WADDR_W-1:0] START_WADDR = 12'h000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vggo,
    input  logic          vgrst,
    output logic          halt,
    output logic          err,
    vg_fetch_if.master    bus
);
    state_t               state_reg;
    logic [WADDR_W-1:0]   pc_reg;
    logic [1:0]           phase_reg;
    logic [7:0]           lo_reg;
    logic [15:0]          word0_reg;
    logic [BADDR_W-1:0]   mem_addr_reg;
    logic                 halt_reg;
    logic                 err_reg;
    logic                 valid_reg;
    opcode_t              op_reg;
    logic [31:0]          data_reg;

    logic [WADDR_W-1:0]   pc_inc;
    logic [WADDR_W-1:0]   pc_issue_next;
    opcode_t              fetched_op;
    opcode_t              exec_op;
    logic                 stk_push;
    logic                 stk_pop;
    logic                 stk_full;
    logic                 stk_empty;
    logic [WADDR_W-1:0]   stk_top;

    assign pc_inc        = pc_reg + 12'd1;
    assign pc_issue_next = pc_reg + ((op_reg == OP_VCTR) ? 12'd2 : 12'd1);
    assign fetched_op    = opcode_t'(bus.mem_data[7:5]);
    assign exec_op       = opcode_t'(word0_reg[15:13]);

    assign halt            = halt_reg;
    assign err             = err_reg;
    assign bus.mem_addr    = mem_addr_reg;
    assign bus.instr_valid = valid_reg;
    assign bus.instr_op    = op_reg;
    assign bus.instr_data  = data_reg;

    always_comb begin
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        if (!vgrst && state_reg == ST_EXEC) begin
            stk_push = (exec_op == OP_JSR) && !stk_full;
            stk_pop  = (exec_op == OP_RTS) && !stk_empty;
        end
    end

    vg_return_stack #(.DEPTH(STACK_DEPTH)) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (vgrst),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // The address for word PC+1 is presented speculatively in the last FETCH
    // cycle so a VCTR extension word arrives without an extra bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            pc_reg       <= START_WADDR;
            phase_reg    <= 2'd0;
            lo_reg       <= 8'h00;
            word0_reg    <= 16'h0000;
            mem_addr_reg <= '0;
            halt_reg     <= 1'b1;
            err_reg      <= 1'b0;
            valid_reg    <= 1'b0;
            op_reg       <= OP_VCTR;
            data_reg     <= 32'h0;
        end else if (vgrst) begin
            state_reg <= ST_IDLE;
            halt_reg  <= 1'b1;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (vggo) begin
                        pc_reg       <= START_WADDR;
                        halt_reg     <= 1'b0;
                        mem_addr_reg <= {START_WADDR, 1'b0};
                        phase_reg    <= 2'd0;
                        state_reg    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    case (phase_reg)
                        2'd0: begin
                            mem_addr_reg <= {pc_reg, 1'b1};
                            phase_reg    <= 2'd1;
                        end
                        2'd1: begin
                            lo_reg       <= bus.mem_data;
                            mem_addr_reg <= {pc_inc, 1'b0};
                            phase_reg    <= 2'd2;
                        end
                        default: begin
                            word0_reg <= {bus.mem_data, lo_reg};
                            phase_reg <= 2'd0;
                            if (fetched_op == OP_VCTR) begin
                                mem_addr_reg <= {pc_inc, 1'b1};
                                state_reg    <= ST_FETCH_EXT;
                            end else if (is_issued(fetched_op)) begin
                                valid_reg <= 1'b1;
                                op_reg    <= fetched_op;
                                data_reg  <= {16'h0000, bus.mem_data, lo_reg};
                                state_reg <= ST_ISSUE;
                            end else begin
                                state_reg <= ST_EXEC;
                            end
                        end
                    endcase
                end
                ST_FETCH_EXT: begin
                    if (phase_reg == 2'd0) begin
                        lo_reg    <= bus.mem_data;
                        phase_reg <= 2'd1;
                    end else begin
                        valid_reg <= 1'b1;
                        op_reg    <= OP_VCTR;
                        data_reg  <= {bus.mem_data, lo_reg, word0_reg};
                        phase_reg <= 2'd0;
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_EXEC: begin
                    case (exec_op)
                        OP_JMP: begin
                            pc_reg       <= word0_reg[11:0];
                            mem_addr_reg <= {word0_reg[11:0], 1'b0};
                            state_reg    <= ST_FETCH;
                        end
                        OP_JSR: begin
                            if (stk_full) begin
                                err_reg   <= 1'b1;
                                halt_reg  <= 1'b1;
                                state_reg <= ST_IDLE;
                            end else begin
                                pc_reg       <= word0_reg[11:0];
                                mem_addr_reg <= {word0_reg[11:0], 1'b0};
                                state_reg    <= ST_FETCH;
                            end
                        end
                        OP_RTS: begin
                            if (stk_empty) begin
                                err_reg   <= 1'b1;
                                halt_reg  <= 1'b1;
                                state_reg <= ST_IDLE;
                            end else begin
                                pc_reg       <= stk_top;
                                mem_addr_reg <= {stk_top, 1'b0};
                                state_reg    <= ST_FETCH;
                            end
                        end
                        default: begin
                            halt_reg  <= 1'b1;
                            state_reg <= ST_IDLE;
                        end
                    endcase
                end
                ST_ISSUE: begin
                    if (bus.instr_ready) begin
                        valid_reg    <= 1'b0;
                        pc_reg       <= pc_issue_next;
                        mem_addr_reg <= {pc_issue_next, 1'b0};
                        phase_reg    <= 2'd0;
                        state_reg    <= ST_FETCH;
                    end
                end
                default: begin
                    halt_reg  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/vg_fetch.md
VG_FETCH -- requirements
Module: vg_fetch

Interface
REQ-001 Parameter STACK_DEPTH, default 4, SHALL set the number of return-stack entries (power of 2).
REQ-002 Parameter START_WADDR, default 12'h000, SHALL set the word address loaded into PC on every start.
REQ-003 clk  input  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 vggo  input  1  SHALL be the CPU start strobe from the address decoder (write to 0x1200).
REQ-006 vgrst  input  1  SHALL be the CPU abort strobe from the address decoder (write to 0x1600).
REQ-007 mem_addr  output  13  SHALL be the vector-RAM byte address.
REQ-008 mem_data  input  8  SHALL be the vector-RAM read data, valid exactly one cycle after mem_addr is presented.
REQ-009 halt  output  1  SHALL be the halt status returned to the CPU status port at 0x800.
REQ-010 instr_valid  output  1  SHALL indicate that instr_op and instr_data hold a draw instruction.
REQ-011 instr_ready  input  1  SHALL be the downstream beam-engine accept signal.
REQ-012 instr_op  output  3  SHALL carry the opcode of the issued instruction.
REQ-013 instr_data  output  32  SHALL carry {word1, word0}; the upper 16 bits are zero for 2-byte instructions.
REQ-014 err  output  1  SHALL be a sticky flag for stack overflow or underflow.

Function
REQ-015 Word assembly: word = {byte at 2*PC+1, byte at 2*PC}; opcode = word[15:13]; PC is a 12-bit word address that wraps 0xFFF->0x000.
REQ-016 Opcodes: 0 VCTR (2 words), 1 HALT, 2 SVEC, 3 STAT/SCAL, 4 CNTR, 5 JSR, 6 RTS, 7 JMP; every opcode except VCTR is 1 word.
REQ-017 FSM states: IDLE, FETCH, FETCH_EXT, EXEC, ISSUE.
REQ-018 IDLE: halt=1; vggo SHALL load PC=START_WADDR, clear halt on the next edge, and enter FETCH.
REQ-019 FETCH SHALL present the two byte addresses on consecutive cycles and capture each byte one cycle later; the word is complete 3 cycles after FETCH entry.
REQ-020 FETCH_EXT (VCTR only) SHALL fetch the second word with the same timing.
REQ-021 EXEC timing: each transfer (JMP, JSR, RTS) costs 1 cycle and then returns to FETCH; HALT returns to IDLE.
REQ-022 JMP SHALL set PC=word[11:0].
REQ-023 JSR SHALL push PC+1 and set PC=word[11:0].
REQ-024 RTS SHALL set PC to the popped value.
REQ-025 HALT SHALL set halt=1 and enter IDLE; HALT is not issued downstream.
REQ-026 Issued opcodes: VCTR, SVEC, STAT/SCAL and CNTR SHALL go to ISSUE.
REQ-027 ISSUE SHALL hold instr_valid=1 with stable op/data until instr_valid&&instr_ready, then advance PC by 1 or 2 and enter FETCH.
REQ-028 Latency from the vggo cycle to instr_valid SHALL be 4 cycles for a 2-byte instruction and 6 cycles for VCTR.
REQ-029 JSR with the stack full SHALL set err=1 and halt=1 and enter IDLE.
REQ-030 RTS with the stack empty SHALL set err=1 and halt=1 and enter IDLE.
REQ-031 err SHALL clear only on vgrst or reset.
REQ-032 vgrst in any state SHALL, on the next edge, enter IDLE with halt=1, instr_valid=0, the stack emptied and err=0.
REQ-033 When vgrst and vggo are asserted together, vgrst SHALL win.
REQ-034 vggo while not IDLE SHALL be ignored.
REQ-035 mem_addr SHALL hold its last value when no fetch is in progress.

Reset
REQ-036 While rst_n=0, outputs SHALL be: halt=1, instr_valid=0, instr_op=0, instr_data=0, err=0, mem_addr=0.
REQ-037 While rst_n=0, internal state SHALL be: state=IDLE, PC=START_WADDR, stack empty.
REQ-038 Deassertion of rst_n SHALL be synchronised externally; the block requires no extra wait cycles.

Structure
REQ-039 Package vg_pkg SHALL hold the opcode enum, the FSM state enum, OP_VCTR..OP_JMP constants and the word-address width (12).
REQ-040 Sub-module vg_return_stack SHALL provide a push/pop LIFO of 12-bit entries with full/empty flags and a synchronous clear; the top entry is readable combinationally.

Verification
REQ-041 Scenario: RAM[0..1]=00 40 (SVEC), RAM[2..3]=00 20 (HALT); vggo with instr_ready=1 -> halt=0 next cycle; instr_valid 4 cycles after vggo with op=2, data=32'h0000_4000; then halt=1.
REQ-042 Scenario: VCTR at word 0 (bytes 34 12 78 56), then HALT -> instr_valid at cycle 6 with op=0, data=32'h5678_1234; PC advances by 2.
REQ-043 Scenario: JSR 0x010 at word 0; word 0x010 holds CNTR then RTS; word 1 holds HALT -> issue order CNTR only; stack empty at end; err=0.
REQ-044 Scenario: five nested JSRs with STACK_DEPTH=4 -> err=1 and halt=1 on the fifth; one RTS at word 0 -> err=1.
REQ-045 Scenario: instr_ready held low for 10 cycles -> instr_valid and data stay stable; accept on cycle 11; next fetch follows.
REQ-046 Scenario: vgrst asserted mid-FETCH, and vgrst+vggo asserted together -> IDLE next cycle with halt=1 and instr_valid=0; no restart.
